// File: rtl/kf_top.sv
// Scalar Kalman-filter datapath: a microcoded sequencer, a 32-entry data bank
// and a sign-magnitude add/sub/mul/div arithmetic unit with a result-valid flag.
module kf_top #(
   parameter int W     = 24,
   parameter int FRAC  = 14,
   parameter int NR    = 32,
   parameter int ADDRW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             START,
   input  logic [W-1:0]     DATA_IN,
   input  logic [ADDRW-1:0] DIR,
   input  logic             WRITE,
   output logic             READY,
   output logic [W-1:0]     DATA_OUT,
   input  logic             rom_we,
   input  logic [7:0]       rom_waddr,
   input  logic [15:0]      rom_wdata
);
   localparam int MW = W - 1;
   localparam int NW = MW + FRAC;
   localparam int PW = 2*MW - FRAC;
   localparam logic [MW-1:0] MAX_MAG = '1;

   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2;
   localparam logic [1:0] C_NORMAL = 2'b00, C_WAIT = 2'b01, C_HALT = 2'b10;
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

   logic [15:0]      rom [256];
   logic [W-1:0]     db [NR];
   logic [1:0]       state;
   logic [7:0]       pc, fetch_pc;
   logic [15:0]      instr;
   logic [ADDRW-1:0] ia, ib;
   logic [1:0]       ic, id;
   logic             exec, au_start, f_write;

   logic             busy, rv, div_ovf, xs, ys, ys_eff, res_s, div_bit;
   logic [4:0]       cnt;
   logic [1:0]       op;
   logic [MW-1:0]    xm, ym, rem, rem_next, quo, res_m;
   logic [W-1:0]     x_op, y_op, nlo, trial, quo_next, result;
   logic [NW-1:0]    dvd;
   logic [MW:0]      sum;
   logic [2*MW-1:0]  prod;
   logic [PW-1:0]    prod_sh;

   // NOTE: the ROM is a plain memory without reset; the host reloads it after power-up.
   always_ff @(posedge clk) begin
      if (rom_we) rom[rom_waddr] <= rom_wdata;
   end

   // Outside RUN the fetch address is forced to 0 so START executes ROM[0] on its own edge.
   assign fetch_pc = (state == S_RUN) ? pc : 8'd0;
   assign instr    = rom[fetch_pc];
   assign ia       = instr[15:11];
   assign ib       = instr[10:6];
   assign ic       = instr[5:4];
   assign id       = instr[3:2];
   assign exec     = (state == S_RUN) || START;
   assign au_start = exec && (ic == C_NORMAL) && instr[1];
   assign f_write  = exec && (ic == C_NORMAL) && instr[0];
   assign READY    = (state == S_HALTED);

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pc    <= '0;
      end else if (exec) begin
         state <= (ic == C_HALT) ? S_HALTED : S_RUN;
         pc    <= (ic == C_WAIT && !rv) ? fetch_pc : fetch_pc + 8'd1;
      end
   end

   assign x_op = db[ia];
   assign y_op = db[ib];
   assign dvd  = NW'(x_op[MW-1:0]) << FRAC;

   // Restoring division step: one quotient bit per cycle, dividend bits shifted in from nlo.
   assign trial    = {rem, nlo[W-1]};
   assign div_bit  = trial >= {1'b0, ym};
   assign rem_next = div_bit ? MW'(trial - {1'b0, ym}) : trial[MW-1:0];
   assign quo_next = {quo, div_bit};

   assign ys_eff  = ys ^ (op == OP_SUB);
   assign sum     = {1'b0, xm} + {1'b0, ym};
   assign prod    = (2*MW)'(xm) * (2*MW)'(ym);
   assign prod_sh = PW'(prod >> FRAC);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      res_s = xs ^ ys;
      res_m = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            if (xs == ys_eff) begin
               res_s = xs;
               res_m = sum[MW] ? MAX_MAG : sum[MW-1:0];
            end else if (xm >= ym) begin
               res_s = xs;
               res_m = xm - ym;
            end else begin
               res_s = ys_eff;
               res_m = ym - xm;
            end
         end
         OP_MUL: res_m = (|prod_sh[PW-1:MW]) ? MAX_MAG : prod_sh[MW-1:0];
         default: begin
            if (ym == '0) res_s = xs;
            res_m = (div_ovf || quo_next[MW]) ? MAX_MAG : quo_next[MW-1:0];
         end
      endcase
      if (res_m == '0) res_s = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0; rv <= 1'b0; div_ovf <= 1'b0; cnt <= '0; op <= OP_ADD;
         xs <= 1'b0; ys <= 1'b0; xm <= '0; ym <= '0;
         rem <= '0; quo <= '0; nlo <= '0; result <= '0;
      end else if (au_start) begin
         busy    <= 1'b1;
         rv      <= 1'b0;
         op      <= id;
         xs      <= x_op[MW];
         xm      <= x_op[MW-1:0];
         ys      <= y_op[MW];
         ym      <= y_op[MW-1:0];
         cnt     <= (id == OP_DIV) ? 5'(W) : (id == OP_MUL) ? 5'd2 : 5'd1;
         rem     <= MW'(dvd[NW-1:W]);
         nlo     <= dvd[W-1:0];
         quo     <= '0;
         // A quotient that needs more than W bits is caught here instead of iterating for it.
         div_ovf <= (x_op[MW-1:0] >> (W - FRAC)) >= y_op[MW-1:0];
      end else begin
         if (busy) begin
            cnt <= cnt - 5'd1;
            rem <= rem_next;
            quo <= quo_next[MW-1:0];
            nlo <= nlo << 1;
            if (cnt == 5'd1) begin
               busy   <= 1'b0;
               rv     <= 1'b1;
               result <= {res_s, res_m};
            end
         end
         if (f_write && rv) rv <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) db[i] <= '0;
      end else begin
         if (f_write) db[ia] <= rv ? result : DATA_IN;
         // Host write comes last so it wins an address collision.
         if (WRITE) db[DIR] <= DATA_IN;
      end
   end

   assign DATA_OUT = db[DIR];
endmodule

// File: tb/tb_kf_top.sv
// Bench for kf_top: directed and randomized AU cases against a value-level
// sign-magnitude model, sequencing/latency corner cases and the 1D KF program.
module tb_kf_top;
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
   localparam logic [15:0] WAIT_I = 16'h0010, HALT_I = 16'h0020, NOP_I = 16'h0030;
   localparam longint MAXM = (64'sd1 <<< 23) - 1;
   localparam logic [23:0] MARK = 24'h123456;

   logic        clk = 1'b0, rst_n = 1'b1, START = 1'b0, WRITE = 1'b0, rom_we = 1'b0;
   logic        READY;
   logic [23:0] DATA_IN = '0, DATA_OUT;
   logic [4:0]  DIR = '0;
   logic [7:0]  rom_waddr = '0;
   logic [15:0] rom_wdata = '0;
   logic [15:0] prog [256];
   int checks = 0, failures = 0;

   kf_top dut (
      .clk(clk), .rst_n(rst_n), .START(START), .DATA_IN(DATA_IN), .DIR(DIR),
      .WRITE(WRITE), .READY(READY), .DATA_OUT(DATA_OUT), .rom_we(rom_we),
      .rom_waddr(rom_waddr), .rom_wdata(rom_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [15:0] op_i(input logic [1:0] d, input logic [4:0] a, input logic [4:0] b);
      return {a, b, 2'b00, d, 1'b1, 1'b0};
   endfunction

   function automatic logic [15:0] f_i(input logic [4:0] a);
      return {a, 5'd0, 2'b00, 2'b00, 1'b0, 1'b1};
   endfunction

   // Reference model: operate on signed integer values, then saturate and repack.
   function automatic longint val(input logic [23:0] x);
      longint m = longint'(x[22:0]);
      return x[23] ? -m : m;
   endfunction

   function automatic logic [23:0] pack(input longint v);
      longint m = (v < 0) ? -v : v;
      logic [22:0] mm;
      if (m > MAXM) m = MAXM;
      mm = m[22:0];
      return {(v < 0), mm};
   endfunction

   function automatic logic [23:0] model(input logic [1:0] op, input logic [23:0] x, input logic [23:0] y);
      longint mx = longint'(x[22:0]);
      longint my = longint'(y[22:0]);
      longint q;
      bit neg = x[23] ^ y[23];
      case (op)
         OP_ADD: return pack(val(x) + val(y));
         OP_SUB: return pack(val(x) - val(y));
         OP_MUL: begin
            q = (mx * my) >> 14;
            return pack(neg ? -q : q);
         end
         default: begin
            if (my == 0) return {x[23], 23'h7FFFFF};
            q = (mx <<< 14) / my;
            return pack(neg ? -q : q);
         end
      endcase
   endfunction

   task automatic load_rom(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rom_we = 1'b1; rom_waddr = 8'(i); rom_wdata = prog[i];
      end
      @(negedge clk);
      rom_we = 1'b0;
   endtask

   task automatic host_write(input logic [4:0] a, input logic [23:0] v);
      @(negedge clk);
      DIR = a; DATA_IN = v; WRITE = 1'b1;
      @(negedge clk);
      WRITE = 1'b0;
   endtask

   task automatic read_db(input logic [4:0] a, output logic [23:0] v);
      DIR = a;
      #1;
      v = DATA_OUT;
   endtask

   task automatic wait_ready(input string name, input int budget, inout int cyc);
      while (READY !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (READY !== 1'b1) begin
         failures++;
         $display("FAIL %s ready: got %b after %0d cycles, expected 1", name, READY, cyc);
      end
   endtask

   task automatic run_prog(input string name, input int budget);
      int cyc = 1;
      @(negedge clk); START = 1'b1;
      @(negedge clk); START = 1'b0;
      wait_ready(name, budget, cyc);
   endtask

   task automatic check_db(input string name, input logic [4:0] a, input logic [23:0] exp);
      logic [23:0] v;
      read_db(a, v);
      checks++;
      if (v !== exp) begin
         failures++;
         $display("FAIL %s: DB[%0d] got %h expected %h", name, a, v, exp);
      end
   endtask

   task automatic au_case(input string name, input logic [1:0] op, input logic [23:0] x,
                          input logic [23:0] y, input logic [23:0] exp);
      host_write(5'd1, x);
      host_write(5'd2, y);
      prog[0] = op_i(op, 5'd1, 5'd2); prog[1] = WAIT_I; prog[2] = f_i(5'd3); prog[3] = HALT_I;
      load_rom(4);
      run_prog(name, 60);
      check_db(name, 5'd3, exp);
   endtask

   task automatic build_kf();
      prog[0]  = f_i(5'd1);  prog[1]  = f_i(5'd3);  prog[2] = f_i(5'd4);
      prog[3]  = f_i(5'd0);  prog[4]  = f_i(5'd2);  prog[5] = f_i(5'd5);
      prog[6]  = op_i(OP_ADD, 5'd2, 5'd3);  prog[7]  = WAIT_I; prog[8]  = f_i(5'd8);
      prog[9]  = op_i(OP_ADD, 5'd8, 5'd4);  prog[10] = WAIT_I; prog[11] = f_i(5'd9);
      prog[12] = op_i(OP_DIV, 5'd8, 5'd9);  prog[13] = WAIT_I; prog[14] = f_i(5'd6);
      prog[15] = op_i(OP_SUB, 5'd5, 5'd0);  prog[16] = WAIT_I; prog[17] = f_i(5'd10);
      prog[18] = op_i(OP_MUL, 5'd6, 5'd10); prog[19] = WAIT_I; prog[20] = f_i(5'd7);
      prog[21] = op_i(OP_ADD, 5'd0, 5'd7);  prog[22] = WAIT_I; prog[23] = f_i(5'd0);
      prog[24] = HALT_I;
   endtask

   // START edge consumes Phi; Q, R, x, P, y follow on the next five edges.
   task automatic kf_stream();
      logic [23:0] vals [6] = '{24'h004000, 24'h0000A3, 24'h000666, 24'h000000, 24'h004000, 24'h00A000};
      @(negedge clk);
      START = 1'b1; DATA_IN = vals[0];
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         START = 1'b0; DATA_IN = vals[i];
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [23:0] v;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (READY !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", READY); end
      for (int i = 0; i < 32; i += 7) begin
         read_db(5'(i), v);
         checks++;
         if (v !== 24'h0) begin failures++; $display("FAIL reset_db: DB[%0d] got %h expected 000000", i, v); end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_rom_no_start();
      int nz = 0;
      logic [23:0] v;
      build_kf();
      load_rom(25);
      repeat (10) @(negedge clk);
      checks++;
      if (READY !== 1'b0) begin failures++; $display("FAIL rom_no_start_ready: got %b expected 0", READY); end
      for (int i = 0; i < 32; i++) begin
         read_db(5'(i), v);
         if (v !== 24'h0) nz++;
      end
      checks++;
      if (nz != 0) begin failures++; $display("FAIL rom_no_start_db: got %0d nonzero entries expected 0", nz); end
   endtask

   task automatic test_host_write();
      host_write(5'd3, 24'h0000A3);
      check_db("host_write_3", 5'd3, 24'h0000A3);
      check_db("host_write_4", 5'd4, 24'h000000);
   endtask

   task automatic test_au_directed();
      au_case("add_1_q",   OP_ADD, 24'h004000, 24'h0000A3, 24'h0040A3);
      au_case("sub_pos",   OP_SUB, 24'h00A000, 24'h0040A3, 24'h005F5D);
      au_case("sub_neg",   OP_SUB, 24'h000000, 24'h004000, 24'h804000);
      au_case("div_k",     OP_DIV, 24'h0040A3, 24'h004709, 24'h003A3C);
      au_case("mul_kinn",  OP_MUL, 24'h003A3C, 24'h00A000, 24'h009196);
      au_case("div_zero",  OP_DIV, 24'h004000, 24'h000000, 24'h7FFFFF);
      au_case("add_sat",   OP_ADD, 24'h7FFFFF, 24'h000001, 24'h7FFFFF);
      au_case("sub_zero",  OP_SUB, 24'h801234, 24'h801234, 24'h000000);
   endtask

   task automatic test_random();
      logic [23:0] x, y;
      logic [1:0]  op;
      for (int i = 0; i < 48; i++) begin
         op = 2'(i % 4);
         x  = {1'($urandom_range(0, 1)), 23'($urandom & ((32'd1 << $urandom_range(1, 23)) - 1))};
         y  = {1'($urandom_range(0, 1)), 23'($urandom & ((32'd1 << $urandom_range(1, 23)) - 1))};
         if ($urandom_range(0, 9) == 0) y[22:0] = '0;
         au_case("random", op, x, y, model(op, x, y));
      end
   endtask

   // An f-write exactly at the latency edge still sees RV=0; one edge later it takes the result.
   task automatic test_latency();
      logic [1:0] ops [3] = '{OP_ADD, OP_MUL, OP_DIV};
      int lats [3] = '{1, 2, 24};
      int k;
      for (int j = 0; j < 3; j++) begin
         for (int dk = 0; dk < 2; dk++) begin
            k = lats[j] + dk;
            host_write(5'd1, 24'h004000);
            host_write(5'd2, 24'h002000);
            prog[0] = op_i(ops[j], 5'd1, 5'd2);
            for (int n = 1; n < k; n++) prog[n] = NOP_I;
            prog[k] = f_i(5'd3); prog[k+1] = HALT_I;
            load_rom(k + 2);
            DATA_IN = MARK;
            run_prog("latency", 80);
            check_db("latency", 5'd3, (dk == 0) ? MARK : model(ops[j], 24'h004000, 24'h002000));
         end
      end
   endtask

   task automatic test_abort();
      host_write(5'd1, 24'h004000);
      host_write(5'd2, 24'h002000);
      prog[0] = op_i(OP_DIV, 5'd1, 5'd2); prog[1] = op_i(OP_ADD, 5'd1, 5'd2);
      prog[2] = WAIT_I; prog[3] = f_i(5'd3);
      for (int n = 4; n < 34; n++) prog[n] = NOP_I;
      prog[34] = f_i(5'd4); prog[35] = HALT_I;
      load_rom(36);
      DATA_IN = MARK;
      run_prog("abort", 80);
      check_db("abort_result", 5'd3, model(OP_ADD, 24'h004000, 24'h002000));
      check_db("abort_no_late", 5'd4, MARK);
   endtask

   task automatic test_host_priority();
      int cyc;
      logic [4:0] dirs [2] = '{5'd5, 5'd6};
      for (int j = 0; j < 2; j++) begin
         host_write(5'd1, 24'h004000);
         host_write(5'd2, 24'h002000);
         host_write(5'd5, 24'h000000);
         host_write(5'd6, 24'h000000);
         prog[0] = op_i(OP_ADD, 5'd1, 5'd2); prog[1] = NOP_I; prog[2] = f_i(5'd5); prog[3] = HALT_I;
         load_rom(4);
         @(negedge clk); START = 1'b1;
         @(negedge clk); START = 1'b0;
         @(negedge clk); WRITE = 1'b1; DIR = dirs[j]; DATA_IN = MARK;
         @(negedge clk); WRITE = 1'b0;
         cyc = 3;
         wait_ready("priority", 40, cyc);
         check_db("priority_db5", 5'd5, (j == 0) ? MARK : model(OP_ADD, 24'h004000, 24'h002000));
         if (j == 1) check_db("priority_db6", 5'd6, MARK);
      end
   endtask

   task automatic kf_check_results(input string name);
      check_db(name, 5'd0, 24'h009196);
      check_db(name, 5'd6, 24'h003A3C);
      check_db(name, 5'd7, 24'h009196);
   endtask

   task automatic test_kf();
      int cyc;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      build_kf();
      load_rom(25);
      kf_stream();
      cyc = 6;
      wait_ready("kf", 80, cyc);
      kf_check_results("kf");
      check_db("kf", 5'd1, 24'h004000);
      check_db("kf", 5'd2, 24'h004000);
      check_db("kf", 5'd3, 24'h0000A3);
      check_db("kf", 5'd4, 24'h000666);
      check_db("kf", 5'd5, 24'h00A000);
   endtask

   task automatic test_reset_mid_div();
      int nz = 0;
      int cyc;
      logic [23:0] v;
      kf_stream();
      repeat (19) @(negedge clk);
      check_db("mid_div_loaded", 5'd1, 24'h004000);
      rst_n = 1'b0;
      #2;
      checks++;
      if (READY !== 1'b0) begin failures++; $display("FAIL mid_div_ready: got %b expected 0", READY); end
      for (int i = 0; i < 32; i++) begin
         read_db(5'(i), v);
         if (v !== 24'h0) nz++;
      end
      checks++;
      if (nz != 0) begin failures++; $display("FAIL mid_div_db_clear: got %0d nonzero entries expected 0", nz); end
      @(negedge clk); rst_n = 1'b1;
      kf_stream();
      cyc = 6;
      wait_ready("kf_rerun", 80, cyc);
      kf_check_results("kf_rerun");
   endtask

   initial begin
      test_reset();
      test_rom_no_start();
      test_host_write();
      test_au_directed();
      test_random();
      test_latency();
      test_abort();
      test_host_priority();
      test_kf();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
